// File: rtl/serial_frame_rx_if.sv
// serial_frame_rx_if: groups the receiver's line, control and output-buffer
// signals. The receiver connects through the slave modport; the driver/consumer
// side connects through the master modport.
interface serial_frame_rx_if #(
  parameter int FRAME_W = 11,
  parameter int CNT_W   = 6
);
  logic               en;
  logic               rx;
  logic               out_ready;
  logic [FRAME_W-1:0] out_data;
  logic               out_valid;
  logic [CNT_W-1:0]   frame_count;
  logic               frame_err;
  logic               overrun;
  logic               busy;

  modport slave (
    input  en, rx, out_ready,
    output out_data, out_valid, frame_count, frame_err, overrun, busy
  );

  modport master (
    output en, rx, out_ready,
    input  out_data, out_valid, frame_count, frame_err, overrun, busy
  );
endinterface

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: single-clock serial frame receiver, one bit per clock.
// Frame = start(0), FRAME_W data bits LSB first, [even parity], stop(1).
// Accepted frames land in a one-entry valid/ready output buffer; a good frame
// arriving while the buffer is full and not being drained is dropped and sets
// the sticky overrun flag.
// Optional feature: define PARITY_CHECK_EN to add the even-parity bit and its
// PARITY state.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for a start bit (rx=0) with en=1
// DATA      | sampling FRAME_W data bits into the shift register
// PARITY    | sampling/checking the parity bit (PARITY_CHECK_EN only)
// STOP      | sampling the stop bit; 1 completes, 0 is a framing error
// WAIT_HIGH | after a framing error, waiting for the line to return high
module serial_frame_rx #(
  parameter int FRAME_W = 11,
  parameter int CNT_W   = 6
) (
  input logic           clk,
  input logic           rst,
  serial_frame_rx_if.slave bus
);

  localparam int BIT_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    DATA,
`ifdef PARITY_CHECK_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic [FRAME_W-1:0] r_shift;
  logic [FRAME_W-1:0] r_data;
  logic               r_valid;
  logic [CNT_W-1:0]   r_count;
  logic               r_err;
  logic               r_ovr;
  logic               w_complete;
  logic               w_err;
`ifdef PARITY_CHECK_EN
  logic               r_par_fail;
  logic               w_par_bad;

  // Even parity: data bits XOR parity bit must be zero.
  assign w_par_bad = (^r_shift) ^ bus.rx;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode plus the frame-complete and frame-error strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_complete  = 1'b0;
    w_err       = 1'b0;
    if (!bus.en) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (!bus.rx) w_state_nxt = DATA;
        end
        DATA: begin
`ifdef PARITY_CHECK_EN
          if (r_bit_cnt == LAST_BIT) w_state_nxt = PARITY;
`else
          if (r_bit_cnt == LAST_BIT) w_state_nxt = STOP;
`endif
        end
`ifdef PARITY_CHECK_EN
        PARITY: begin
          w_state_nxt = STOP;
          w_err       = w_par_bad;
        end
`endif
        STOP: begin
`ifdef PARITY_CHECK_EN
          // A parity failure already pulsed frame_err; the stop bit then only
          // decides whether to wait for the line to recover.
          if (bus.rx) begin
            w_state_nxt = IDLE;
            w_complete  = ~r_par_fail;
          end else begin
            w_state_nxt = WAIT_HIGH;
            w_err       = ~r_par_fail;
          end
`else
          if (bus.rx) begin
            w_state_nxt = IDLE;
            w_complete  = 1'b1;
          end else begin
            w_state_nxt = WAIT_HIGH;
            w_err       = 1'b1;
          end
`endif
        end
        WAIT_HIGH: begin
          if (bus.rx) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Bit counter and shift register; counter is held clear while idle so a
  // start bit always begins at bit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (r_state == IDLE) begin
      r_bit_cnt <= '0;
    end else if (r_state == DATA && bus.en) begin
      r_shift[r_bit_cnt] <= bus.rx;
      r_bit_cnt          <= r_bit_cnt + 1'b1;
    end
  end

`ifdef PARITY_CHECK_EN
  // Remember a parity failure until the stop bit has been sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              r_par_fail <= 1'b0;
    else if (r_state == IDLE)             r_par_fail <= 1'b0;
    else if (r_state == PARITY && bus.en) r_par_fail <= w_par_bad;
  end
`endif

  // Output buffer, frame counter, error pulse and sticky overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_count <= '0;
      r_err   <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_err <= w_err;
      if (w_complete) begin
        if (!r_valid || bus.out_ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
          r_count <= r_count + 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && bus.out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.out_data    = r_data;
  assign bus.out_valid   = r_valid;
  assign bus.frame_count = r_count;
  assign bus.frame_err   = r_err;
  assign bus.overrun     = r_ovr;
  assign bus.busy        = (r_state != IDLE);

endmodule

// File: doc/serial_frame_rx.md
SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 The module SHALL have parameter FRAME_W, default 11, meaning the number of data bits per frame (legal range 1..32).
REQ-002 The module SHALL have parameter CNT_W, default 6, meaning the width of the accepted-frame counter.
REQ-003 clk  input  1  Single clock; all state updates on the rising edge.
REQ-004 rst  input  1  Reset, asynchronous, active-high.
REQ-005 en  input  1  Receiver enable; 0 aborts or inhibits reception.
REQ-006 rx  input  1  Serial line; idles high.
REQ-007 out_data  output  FRAME_W  Received frame, LSB = first data bit received.
REQ-008 out_valid  output  1  out_data holds an unconsumed frame.
REQ-009 out_ready  input  1  Consumer accepts out_data when high with out_valid.
REQ-010 frame_count  output  CNT_W  Count of accepted frames, modulo 2^CNT_W.
REQ-011 frame_err  output  1  One-cycle pulse on a stop-bit error or parity error.
REQ-012 overrun  output  1  Sticky flag: a good frame was dropped because the buffer was full.
REQ-013 busy  output  1  High in any state other than IDLE.

Function
REQ-014 FSM states SHALL be: IDLE, DATA, PARITY (present only with PARITY_CHECK_EN), STOP and WAIT_HIGH.
REQ-015 IDLE SHALL go to DATA when en=1 and rx=0 are sampled (start bit); the bit counter is cleared at the same time.
REQ-016 DATA SHALL sample one rx bit per cycle into bit position [bit counter], for FRAME_W cycles.
REQ-017 After the last data bit, DATA SHALL go to PARITY if it is compiled in, else to STOP.
REQ-018 STOP SHALL sample rx: 1 completes the frame and returns to IDLE; 0 pulses frame_err, discards the frame and goes to WAIT_HIGH.
REQ-019 WAIT_HIGH SHALL return to IDLE on the first sampled rx=1.
REQ-020 A completed frame SHALL be written to the one-entry output buffer: out_data updates and out_valid rises in the cycle after the stop bit is sampled.
REQ-021 frame_count SHALL increment in that same cycle, and SHALL wrap from 2^CNT_W-1 to 0.
REQ-022 A handshake SHALL occur when out_valid=1 and out_ready=1; out_valid then clears next cycle unless a new frame is loaded in that same cycle.
REQ-023 When a frame completes while out_valid=1 and out_ready=1 in the same cycle, the new frame SHALL be loaded, out_valid SHALL stay 1, and overrun SHALL not set.
REQ-024 When a frame completes while out_valid=1 and out_ready=0, the new frame SHALL be dropped, the old out_data SHALL be held, overrun SHALL set, and frame_count SHALL not increment.
REQ-025 When en=0 is sampled in any state, the FSM SHALL go to IDLE and discard the partial frame; out_valid, out_data and frame_count SHALL be unaffected.
REQ-026 out_data SHALL remain stable while out_valid=1 and no handshake has occurred.

Reset
REQ-027 While rst=1, the module SHALL asynchronously set: state=IDLE, bit counter=0, out_data=0, out_valid=0, frame_count=0, frame_err=0, overrun=0, busy=0.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame; the first start bit detected after release SHALL begin a fresh frame.
REQ-029 overrun SHALL be cleared only by rst.

Configuration
REQ-030 Macro PARITY_CHECK_EN defined: the frame SHALL be start, FRAME_W data bits, one even-parity bit, stop.
REQ-031 With PARITY_CHECK_EN defined, the parity bit SHALL be checked so that the XOR of the data and parity bits equals 0.
REQ-032 With PARITY_CHECK_EN defined, a parity mismatch SHALL pulse frame_err, discard the frame (not count it) and continue to STOP; a stop-bit error in that case does not produce a second frame_err pulse.
REQ-033 Macro PARITY_CHECK_EN undefined: there SHALL be no PARITY state and no parity bit; the frame is start, data, stop.

Verification (FRAME_W=11, CNT_W=6)
REQ-034 Frame: rx = 0, data 0x5A3 LSB first, then 1, out_ready=0 -> out_valid=1 and out_data=0x5A3 one cycle after the stop bit; frame_count=1; busy=0.
REQ-035 Second good frame 0x001 with out_ready held 0 -> out_data stays 0x5A3, overrun=1, frame_count stays 1; then out_ready=1 for one cycle -> out_valid=0.
REQ-036 Frame 0x7FF with stop bit 0, then rx held low for 5 cycles -> one-cycle frame_err pulse; FSM stays in WAIT_HIGH (busy=1) with no restart until rx=1.
REQ-037 en dropped after 4 data bits, then a full frame 0x2AA -> out_data=0x2AA and the partial frame is lost; also rst pulsed mid-frame -> all outputs 0.
REQ-038 64 consecutive good frames, each consumed -> frame_count wraps 63->0; out_ready=1 on the completion cycle -> no overrun.
REQ-039 With PARITY_CHECK_EN: data 0x003 with parity bit 1 -> frame_err pulse, out_valid unchanged, frame_count unchanged; with parity bit 0 -> accepted.
